// File: rtl/prga_decryptor.sv
// prga_decryptor: RC4 keystream generator and message decryptor over the shared S-RAM.
// Optional early abort on a non-[a-z ] plaintext byte: RC4_PRGA_PLAINTEXT_CHECK_EN.
module prga_decryptor #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic              key_bad,
  output logic              s_owner,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wen,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wen
);

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    RD_SI,
    WAIT_SI,
    STORE_SI,
    RD_SJ,
    WAIT_SJ,
    STORE_SJ,
    WR_I,
    WR_J,
    RD_F,
    WAIT_F,
    STORE_F,
    WR_DEC,
    CHECK,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MSG_LEN - 1);

  state_t state;
  state_t state_nx;

  logic [7:0]        i;
  logic [7:0]        j;
  logic [ADDR_W-1:0] k;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [7:0]        f;
  logic [7:0]        enc;
  logic [7:0]        plain;
  logic [7:0]        f_addr;
  logic              last;
  logic              abort;

  assign plain  = f ^ enc;
  assign f_addr = si + sj;
  assign last   = (k == LAST);

`ifdef RC4_PRGA_PLAINTEXT_CHECK_EN
  logic key_bad_q;
  logic plain_ok;

  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7a))
                  || (plain == 8'h20);
  assign abort    = key_bad_q;
  assign key_bad  = key_bad_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_bad_q <= 1'b0;
    end else if (state == IDLE && start) begin
      key_bad_q <= 1'b0;
    end else if (state == WR_DEC && !plain_ok) begin
      key_bad_q <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign key_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i   <= 8'd0;
      j   <= 8'd0;
      k   <= '0;
      si  <= 8'd0;
      sj  <= 8'd0;
      f   <= 8'd0;
      enc <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= '0;
          end
        end
        INC_I: i <= i + 8'd1;
        STORE_SI: begin
          si <= s_q;
          j  <= j + s_q;
        end
        STORE_SJ: sj <= s_q;
        STORE_F: begin
          f   <= s_q;
          enc <= rom_q;
        end
        CHECK: begin
          if (!last && !abort) begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:     state_nx = start ? INC_I : IDLE;
      INC_I:    state_nx = RD_SI;
      RD_SI:    state_nx = WAIT_SI;
      WAIT_SI:  state_nx = STORE_SI;
      STORE_SI: state_nx = RD_SJ;
      RD_SJ:    state_nx = WAIT_SJ;
      WAIT_SJ:  state_nx = STORE_SJ;
      STORE_SJ: state_nx = WR_I;
      WR_I:     state_nx = WR_J;
      WR_J:     state_nx = RD_F;
      RD_F:     state_nx = WAIT_F;
      WAIT_F:   state_nx = STORE_F;
      STORE_F:  state_nx = WR_DEC;
      WR_DEC:   state_nx = CHECK;
      CHECK:    state_nx = (last || abort) ? DONE : INC_I;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Read addresses are held through WAIT/STORE so the RAM output stays stable.
  always_comb begin
    finish      = 1'b0;
    s_owner     = (state != IDLE);
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wen       = 1'b0;
    rom_address = '0;
    dec_address = '0;
    dec_data    = 8'd0;
    dec_wen     = 1'b0;
    case (state)
      RD_SI,
      WAIT_SI,
      STORE_SI: s_address = i;
      RD_SJ,
      WAIT_SJ,
      STORE_SJ: s_address = j;
      WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wen     = 1'b1;
      end
      WR_J: begin
        s_address = j;
        s_data    = si;
        s_wen     = 1'b1;
      end
      RD_F,
      WAIT_F,
      STORE_F: begin
        s_address   = f_addr;
        rom_address = k;
      end
      WR_DEC: begin
        dec_address = k;
        dec_data    = plain;
        dec_wen     = 1'b1;
      end
      DONE: finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga_decryptor.sv
// tb_prga_decryptor: self-checking bench for prga_decryptor.
// Memory models, reference RC4 scoreboard, table vectors and reset/abort sequences.
module tb_prga_decryptor;
  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              finish;
  logic              key_bad;
  logic              s_owner;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wen;
  logic [7:0]        s_q;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_q;
  logic [ADDR_W-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wen;

  prga_decryptor #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .finish(finish), .key_bad(key_bad), .s_owner(s_owner),
    .s_address(s_address), .s_data(s_data), .s_wen(s_wen),
    .s_q(s_q), .rom_address(rom_address), .rom_q(rom_q),
    .dec_address(dec_address), .dec_data(dec_data), .dec_wen(dec_wen)
  );

  always #5 clk = ~clk;

  logic [7:0] smem [256];
  logic [7:0] s_init [256];
  logic [7:0] rom [MSG_LEN];
  logic [7:0] dmem [MSG_LEN];
  logic [7:0] s_q_r;
  logic [7:0] rom_q_r;
  logic       load = 1'b0;

  assign s_q   = s_q_r;
  assign rom_q = rom_q_r;

  // Synchronous-read RAMs: address sampled at the edge, data valid next cycle.
  always @(posedge clk) begin
    s_q_r   <= smem[s_address];
    rom_q_r <= rom[rom_address];
    if (load) begin
      smem <= s_init;
      for (int x = 0; x < MSG_LEN; x++) dmem[x] <= 8'hEE;
    end else begin
      if (s_wen) smem[s_address] <= s_data;
      if (dec_wen) dmem[dec_address] <= dec_data;
    end
  end

  typedef struct {
    int         addr;
    logic [7:0] data;
  } dec_t;

  typedef struct {
    int         k;
    logic [7:0] enc;
    logic [7:0] dec;
  } vec_t;

  dec_t       sb [$];
  logic [15:0] swlog [$];
  logic [7:0] exp_s [256];
  logic [7:0] exp_d [MSG_LEN];
  logic [7:0] ks [MSG_LEN];
  logic [7:0] snap [256];
  int         exp_n;
  int         nvec = 0;
  int         nfail = 0;
  int         sw_cnt = 0;
  int         dw_cnt = 0;
  int         fin_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void gen_keystream();
    logic [7:0] s [256];
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    s = s_init;
    a = 0;
    b = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      t = s[a] + s[b];
      ks[k] = s[t];
    end
  endfunction

  // Reference RC4 run: fills the scoreboard, final S and expected dec RAM.
  function automatic void model_run();
    logic [7:0] s [256];
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] t;
    logic [7:0] p;
    s = s_init;
    a = 0;
    b = 0;
    exp_n = 0;
    for (int k = 0; k < MSG_LEN; k++) exp_d[k] = 8'hEE;
    for (int k = 0; k < MSG_LEN; k++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      t = s[a] + s[b];
      p = s[t] ^ rom[k];
      sb.push_back('{k, p});
      exp_d[k] = p;
      exp_n++;
`ifdef RC4_PRGA_PLAINTEXT_CHECK_EN
      if (!(((p >= 8'h61) && (p <= 8'h7a)) || p == 8'h20)) break;
`endif
    end
    exp_s = s;
  endfunction

  task automatic load_mem();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int max_edges, output int edges,
                     output bit fin);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    fin = 1'b0;
    while (edges < max_edges && !fin) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) chk("owner_high", s_owner, 1);
      if (s_wen) begin
        sw_cnt++;
        swlog.push_back({s_address, s_data});
      end
      if (dec_wen) begin
        dw_cnt++;
        if (dec_address == 2) snap = smem;
        if (sb.size() == 0) begin
          chk("dec_unexpected", 1, 0);
        end else begin
          dec_t e;
          e = sb.pop_front();
          chk("dec_addr", 32'(dec_address), e.addr);
          chk("dec_data", dec_data, e.data);
        end
      end
      if (finish) begin
        fin = 1'b1;
        fin_cnt++;
      end
    end
  endtask

  task automatic check_after(input string tag, input int edges);
    int bad;
    chk({tag, "_fin_time"}, edges, 14 * exp_n);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    @(posedge clk);
    #1;
    chk({tag, "_fin_pulse"}, finish, 0);
    chk({tag, "_owner_low"}, s_owner, 0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (smem[x] !== exp_s[x]) bad++;
    chk({tag, "_s_final"}, bad, 0);
    bad = 0;
    for (int x = 0; x < MSG_LEN; x++) if (dmem[x] !== exp_d[x]) bad++;
    chk({tag, "_dec_ram"}, bad, 0);
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic plain_rom();
    gen_keystream();
    for (int k = 0; k < MSG_LEN; k++)
      rom[k] = ks[k] ^ 8'(8'h61 + (k % 26));
  endtask

  initial begin
    vec_t vt [3];
    int   edges;
    int   sw0;
    int   dw0;
    int   fc0;
    bit   fin;
    logic [7:0] t;
    int   r;

    vt[0] = '{0, 8'h63, 8'h61};
    vt[1] = '{1, 8'h66, 8'h63};
    vt[2] = '{2, 8'h66, 8'h61};

    #2;
    chk("rst_owner", s_owner, 0);
    chk("rst_wen", {s_wen, dec_wen, finish, key_bad}, 0);
    chk("rst_addr", {s_address, s_data, 3'b0, dec_address, dec_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Identity S, table-driven first bytes.
    identity_s();
    plain_rom();
    for (int v = 0; v < 3; v++) rom[vt[v].k] = vt[v].enc;
    model_run();
    load_mem();
    swlog.delete();
    sw0 = sw_cnt; dw0 = dw_cnt; fc0 = fin_cnt;
    chk("owner_pre", s_owner, 0);
    run(1000, edges, fin);
    for (int v = 0; v < 3; v++)
      chk($sformatf("vec_dec%0d", vt[v].k), dmem[vt[v].k], vt[v].dec);
    chk("ieqj_wr_i", swlog[0], 16'h0101);
    chk("ieqj_wr_j", swlog[1], 16'h0101);
    chk("swap_wr2", {swlog[2], swlog[3]}, 32'h0203_0302);
    chk("snap_s1", snap[1], 8'h01);
    chk("snap_s235", {snap[2], snap[3], snap[5]}, 24'h03_05_02);
    chk("id_s_wen", sw_cnt - sw0, 2 * exp_n);
    chk("id_dec_wen", dw_cnt - dw0, exp_n);
    chk("id_finish", fin_cnt - fc0, 1);
    check_after("id", edges);

    // Random permutation S.
    identity_s();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
    end
    plain_rom();
    model_run();
    load_mem();
    sw0 = sw_cnt; dw0 = dw_cnt; fc0 = fin_cnt;
    run(1000, edges, fin);
    chk("rnd_fin448", edges, 448);
    chk("rnd_s_wen", sw_cnt - sw0, 64);
    chk("rnd_dec_wen", dw_cnt - dw0, 32);
    chk("rnd_finish", fin_cnt - fc0, 1);
    check_after("rnd", edges);

    // Bad plaintext at byte 1.
    identity_s();
    plain_rom();
    rom[1] = 8'h00;
    model_run();
    load_mem();
    run(1000, edges, fin);
`ifdef RC4_PRGA_PLAINTEXT_CHECK_EN
    chk("bad_key_bad", key_bad, 1);
    chk("bad_fin28", edges, 28);
    chk("bad_dec1", dmem[1], 8'h05);
`else
    chk("bad_key_bad", key_bad, 0);
    chk("bad_fin448", edges, 448);
`endif
    check_after("bad", edges);

    // Reset in WAIT_F of byte 10, then clean restart.
    identity_s();
    plain_rom();
    model_run();
    load_mem();
    run(150, edges, fin);
    chk("rst_mid_key_bad", key_bad, 0);
    chk("rst_mid_owner", s_owner, 1);
    chk("rst_mid_addr", s_address, 8'h00 + s_address);
    reset = 1'b0;
    #1;
    chk("rst_mid_owner0", s_owner, 0);
    chk("rst_mid_ctl0", {s_wen, dec_wen, finish, key_bad}, 0);
    chk("rst_mid_bus0",
        {s_address, s_data, 3'b0, dec_address, 3'b0, rom_address}, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    model_run();
    load_mem();
    run(1000, edges, fin);
    check_after("restart", edges);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
